action_tx_engine: RTL and testbench
===================================

ACTION_TX_ENGINE -- requirements
Module: action_tx_engine

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 192, header buffer capacity in bytes.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port hdr_valid, input, 1, header descriptor valid.
REQ-006 SHALL have port hdr_flat, input, 8*HDR_BYTES, header bytes; byte i at bits [8i+7:8i].
REQ-007 SHALL have port hdr_len, input, 9, header length in bytes.
REQ-008 SHALL have port has_vlan, input, 1, header carries an 802.1Q tag.
REQ-009 SHALL have port is_ipv4, input, 1, header carries IPv4.
REQ-010 SHALL have port act_valid, input, 1, action word valid.
REQ-011 SHALL have port action, input, 64, action word from action memory.
REQ-012 SHALL have port in_ready, output, 1, block accepts a descriptor.
REQ-013 SHALL have port tx_valid / tx_data / tx_last, output, 1/8/1, egress byte stream.
REQ-014 SHALL have port tx_ready, input, 1, downstream accepts byte.
REQ-015 SHALL have port tx_port, output, 4, egress port of current packet.
REQ-016 SHALL have ports tx_pkt_cnt and drop_cnt, output, CNT_W each, statistics.

Function
REQ-017 Action fields SHALL be: bit0 drop, bit1 dec_ttl, bit2 set_dscp, [8:3] dscp, bit9 set_vid, [21:10] vid, [25:22] port; [63:26] ignored.
REQ-018 Acceptance SHALL occur when in_ready && hdr_valid && act_valid in one cycle; descriptor, flags and action latched.
REQ-019 FSM states SHALL be IDLE (in_ready=1) and SEND (in_ready=0); IDLE->SEND on acceptance not dropped; SEND->IDLE on handshake of tx_last byte.
REQ-020 Accepted packet SHALL be dropped (remain IDLE, drop_cnt+1, no tx) if drop=1, hdr_len==0, hdr_len>HDR_BYTES, or dec_ttl with IPv4 edits enabled and TTL<=1.
REQ-021 tx_valid SHALL rise the cycle after acceptance; byte k sent is edited byte k, k=0..hdr_len-1; tx_last=1 only with k=hdr_len-1.
REQ-022 Index SHALL advance only on tx_valid && tx_ready; tx_data/tx_last/tx_port SHALL hold stable while stalled.
REQ-023 tx_pkt_cnt SHALL increment on last-byte handshake; both counters wrap at 2^CNT_W.
REQ-024 IPv4 base B SHALL be 18 if has_vlan else 14; IPv4 edits apply only if is_ipv4 and hdr_len>=B+20.
REQ-025 dec_ttl SHALL replace byte B+8 with TTL-1; set_dscp SHALL replace byte B+1 upper 6 bits with dscp, keeping ECN bits.
REQ-026 set_vid SHALL, only if has_vlan, replace byte 14 low nibble and byte 15 with vid, keeping PCP/DEI.
REQ-027 Edits SHALL be computed from the latched descriptor; back-to-back packets SHALL have one IDLE cycle between them.

Reset
REQ-028 On rst_n low: state IDLE, in_ready=1 after release, tx_valid=0, tx_last=0, tx_data=0, tx_port=0, counters=0.
REQ-029 Reset mid-packet SHALL discard the packet without counting it.

Configuration
REQ-030 With ACTION_TX_CSUM_FIX_EN defined, bytes B+10..B+11 SHALL carry the RFC 1624 incremental checksum HC'=~(~HC+~m0+m0'+~m8+m8') (end-around carry) over changed words at B+0 and B+8.
REQ-031 Without ACTION_TX_CSUM_FIX_EN, checksum bytes SHALL pass unmodified.

Structure
REQ-032 Package dp_action_pkg SHALL hold action-field bit positions, Ethernet/VLAN/IPv4 offsets and state encoding.
REQ-033 Checksum update SHALL be sub-module ipv4_csum_update, instantiated only under ACTION_TX_CSUM_FIX_EN.

Verification
REQ-034 Pass-through: 60-byte untagged IPv4, action=0, port=3 -> 60 bytes identical, tx_last on byte 59, tx_port=3, tx_pkt_cnt=1.
REQ-035 TTL: IPv4 TTL=64, csum=0xB1E6, dec_ttl -> byte 22=63; with macro csum=0xB2E6, without 0xB1E6.
REQ-036 Drop: drop=1 -> no tx_valid, drop_cnt=1; TTL=1 with dec_ttl -> drop_cnt=2.
REQ-037 VLAN: tagged header TCI=0xA005, set_vid vid=0x123, set_dscp=46 on TOS 0x01 -> bytes 14..15=0xA1,0x23; byte 19=0xB9.
REQ-038 Backpressure: tx_ready toggles 1010..., then rst_n pulsed at byte 10 -> stable data while stalled, all outputs reset, tx_pkt_cnt unchanged.

Source files
------------

// File: rtl/dp_action_pkg.sv
// Shared definitions for the action transmit engine: action-word field
// positions, Ethernet/VLAN/IPv4 byte offsets and the FSM state encoding.
package dp_action_pkg;

    // Action word field positions
    localparam int unsigned ACT_DROP      = 0;
    localparam int unsigned ACT_DEC_TTL   = 1;
    localparam int unsigned ACT_SET_DSCP  = 2;
    localparam int unsigned ACT_DSCP_LSB  = 3;
    localparam int unsigned ACT_DSCP_W    = 6;
    localparam int unsigned ACT_SET_VID   = 9;
    localparam int unsigned ACT_VID_LSB   = 10;
    localparam int unsigned ACT_VID_W     = 12;
    localparam int unsigned ACT_PORT_LSB  = 22;
    localparam int unsigned ACT_PORT_W    = 4;
    localparam int unsigned ACT_USED_BITS = 26;

    // Header byte offsets
    localparam int unsigned ETH_IP_BASE   = 14;
    localparam int unsigned VLAN_IP_BASE  = 18;
    localparam int unsigned VLAN_TCI_OFS  = 14;
    localparam int unsigned IP_TOS_OFS    = 1;
    localparam int unsigned IP_TTL_OFS    = 8;
    localparam int unsigned IP_CSUM_OFS   = 10;
    localparam int unsigned IP_MIN_LEN    = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // Edit controls retained for the packet in flight (drop is consumed at acceptance)
    typedef struct packed {
        logic        dec_ttl;
        logic        set_dscp;
        logic [5:0]  dscp;
        logic        set_vid;
        logic [11:0] vid;
        logic [3:0]  port;
    } action_t;

endpackage

// File: rtl/ipv4_csum_update.sv
// Incremental IPv4 header checksum update (RFC 1624) for two changed
// 16-bit words: HC' = ~(~HC + ~m0 + m0' + ~m8 + m8'), end-around carry.
module ipv4_csum_update
    import dp_action_pkg::*;
(
    input  logic [15:0] csum_old,
    input  logic [15:0] m0_old,
    input  logic [15:0] m0_new,
    input  logic [15:0] m8_old,
    input  logic [15:0] m8_new,
    output logic [15:0] csum_new
);

    logic [15:0] n_csum, n_m0, n_m8;
    logic [18:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Ones' complement sum of five 16-bit terms, folded back to 16 bits
    always_comb begin
        n_csum   = ~csum_old;
        n_m0     = ~m0_old;
        n_m8     = ~m8_old;
        sum      = {3'b000, n_csum} + {3'b000, n_m0} + {3'b000, m0_new}
                 + {3'b000, n_m8} + {3'b000, m8_new};
        fold1    = {1'b0, sum[15:0]} + {14'd0, sum[18:16]};
        fold2    = fold1[15:0] + {15'd0, fold1[16]};
        csum_new = ~fold2;
    end

endmodule

// File: rtl/action_tx_engine.sv
// Action transmit engine: accepts a header descriptor plus action word,
// drops it or streams the edited header bytes out one per handshake.
// Optional feature macro: ACTION_TX_CSUM_FIX_EN (incremental IPv4 checksum fix).
module action_tx_engine
    import dp_action_pkg::*;
#(
    parameter int unsigned HDR_BYTES = 192,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hdr_valid,
    input  logic [8*HDR_BYTES-1:0] hdr_flat,
    input  logic [8:0]             hdr_len,
    input  logic                   has_vlan,
    input  logic                   is_ipv4,
    input  logic                   act_valid,
    input  logic [63:0]            action,
    output logic                   in_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_last,
    input  logic                   tx_ready,
    output logic [3:0]             tx_port,
    output logic [CNT_W-1:0]       tx_pkt_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    tx_state_t              state_q, state_d;
    logic [8*HDR_BYTES-1:0] hdr_q;
    logic [8:0]             len_q, idx_q;
    logic                   vlan_q, ip_ok_q;
    action_t                act_q, act_in;
    logic [8:0]             base_in, base_q;
    logic                   ip_ok_in, drop_in, accept, fire, last_byte;
    logic [7:0]             ttl_in, raw, out_byte;
    logic [CNT_W-1:0]       pkt_cnt_q, drop_cnt_q;
    logic                   act_unused;

    function automatic logic [7:0] byte_at(input logic [8*HDR_BYTES-1:0] flat,
                                           input logic [8:0] k);
        byte_at = '0;
        for (int unsigned i = 0; i < HDR_BYTES; i++) begin
            if (k == 9'(i)) byte_at = flat[8*i +: 8];
        end
    endfunction

    assign act_unused = ^action[63:ACT_USED_BITS];

    // Decode the incoming action and decide whether the descriptor is dropped
    always_comb begin
        act_in.dec_ttl  = action[ACT_DEC_TTL];
        act_in.set_dscp = action[ACT_SET_DSCP];
        act_in.dscp     = action[ACT_DSCP_LSB +: ACT_DSCP_W];
        act_in.set_vid  = action[ACT_SET_VID];
        act_in.vid      = action[ACT_VID_LSB +: ACT_VID_W];
        act_in.port     = action[ACT_PORT_LSB +: ACT_PORT_W];
        base_in         = has_vlan ? 9'(VLAN_IP_BASE) : 9'(ETH_IP_BASE);
        ip_ok_in        = is_ipv4 && (hdr_len >= base_in + 9'(IP_MIN_LEN));
        ttl_in          = byte_at(hdr_flat, base_in + 9'(IP_TTL_OFS));
        drop_in         = action[ACT_DROP] || (hdr_len == '0) || (32'(hdr_len) > HDR_BYTES)
                       || (act_in.dec_ttl && ip_ok_in && (ttl_in <= 8'd1));
    end

    assign accept    = in_ready && hdr_valid && act_valid;
    assign fire      = tx_valid && tx_ready;
    assign last_byte = (idx_q == len_q - 9'd1);
    assign base_q    = vlan_q ? 9'(VLAN_IP_BASE) : 9'(ETH_IP_BASE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !drop_in) state_d = ST_SEND;
            ST_SEND: if (fire && last_byte)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs derived from state and the latched packet
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        tx_valid = (state_q == ST_SEND);
        tx_last  = tx_valid && last_byte;
        tx_data  = tx_valid ? out_byte : '0;
        tx_port  = act_q.port;
    end

`ifdef ACTION_TX_CSUM_FIX_EN
    logic [15:0] csum_old, csum_new, m0_old, m0_new, m8_old, m8_new;
    logic [7:0]  tos_old, ttl_old;

    // Collect the original and edited IPv4 words feeding the checksum fix
    always_comb begin
        tos_old  = byte_at(hdr_q, base_q + 9'(IP_TOS_OFS));
        ttl_old  = byte_at(hdr_q, base_q + 9'(IP_TTL_OFS));
        m0_old   = {byte_at(hdr_q, base_q), tos_old};
        m0_new   = {m0_old[15:8], act_q.set_dscp ? {act_q.dscp, tos_old[1:0]} : tos_old};
        m8_old   = {ttl_old, byte_at(hdr_q, base_q + 9'(IP_TTL_OFS + 1))};
        m8_new   = {act_q.dec_ttl ? ttl_old - 8'd1 : ttl_old, m8_old[7:0]};
        csum_old = {byte_at(hdr_q, base_q + 9'(IP_CSUM_OFS)),
                    byte_at(hdr_q, base_q + 9'(IP_CSUM_OFS + 1))};
    end

    ipv4_csum_update u_csum (
        .csum_old (csum_old),
        .m0_old   (m0_old),
        .m0_new   (m0_new),
        .m8_old   (m8_old),
        .m8_new   (m8_new),
        .csum_new (csum_new)
    );
`endif

    // Edited byte at the current index, applied on the fly to the latched header
    always_comb begin
        raw      = byte_at(hdr_q, idx_q);
        out_byte = raw;
        if (ip_ok_q && act_q.set_dscp && idx_q == base_q + 9'(IP_TOS_OFS))
            out_byte = {act_q.dscp, raw[1:0]};
        if (ip_ok_q && act_q.dec_ttl && idx_q == base_q + 9'(IP_TTL_OFS))
            out_byte = raw - 8'd1;
`ifdef ACTION_TX_CSUM_FIX_EN
        if (ip_ok_q && (act_q.dec_ttl || act_q.set_dscp)) begin
            if (idx_q == base_q + 9'(IP_CSUM_OFS))     out_byte = csum_new[15:8];
            if (idx_q == base_q + 9'(IP_CSUM_OFS + 1)) out_byte = csum_new[7:0];
        end
`endif
        if (vlan_q && act_q.set_vid && idx_q == 9'(VLAN_TCI_OFS))
            out_byte = {raw[7:4], act_q.vid[11:8]};
        if (vlan_q && act_q.set_vid && idx_q == 9'(VLAN_TCI_OFS + 1))
            out_byte = act_q.vid[7:0];
    end

    // Latch the accepted descriptor and walk the byte index on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            vlan_q  <= 1'b0;
            ip_ok_q <= 1'b0;
            act_q   <= '0;
        end else if (accept && !drop_in) begin
            hdr_q   <= hdr_flat;
            len_q   <= hdr_len;
            idx_q   <= '0;
            vlan_q  <= has_vlan;
            ip_ok_q <= ip_ok_in;
            act_q   <= act_in;
        end else if (fire) begin
            idx_q   <= idx_q + 9'd1;
        end
    end

    // Statistics counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept && drop_in)  drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            if (fire && last_byte)  pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
        end
    end

    assign tx_pkt_cnt = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_action_tx_engine.sv
// Scoreboard bench for action_tx_engine: a byte-array reference model pushes
// expected output bytes at acceptance; a monitor pops and compares them.
module tb_action_tx_engine;

    localparam int HB = 192;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hdr_valid = 1'b0;
    logic [8*HB-1:0] hdr_flat = '0;
    logic [8:0]      hdr_len = '0;
    logic            has_vlan = 1'b0;
    logic            is_ipv4 = 1'b0;
    logic            act_valid = 1'b0;
    logic [63:0]     action = '0;
    logic            in_ready, tx_valid, tx_last;
    logic            tx_ready = 1'b1;
    logic [7:0]      tx_data;
    logic [3:0]      tx_port;
    logic [CW-1:0]   tx_pkt_cnt, drop_cnt;

    action_tx_engine #(.HDR_BYTES(HB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdr_valid  (hdr_valid),
        .hdr_flat   (hdr_flat),
        .hdr_len    (hdr_len),
        .has_vlan   (has_vlan),
        .is_ipv4    (is_ipv4),
        .act_valid  (act_valid),
        .action     (action),
        .in_ready   (in_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_port    (tx_port),
        .tx_pkt_cnt (tx_pkt_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] port;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] model_pkt = '0;
    logic [CW-1:0] model_drop = '0;
    int            hs_count = 0;
    int            ready_mode = 0;
    bit            pkt_pending = 0;
    logic [7:0]    cur_hdr [HB];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] mk_act(bit drop, bit dec, bit sd, logic [5:0] dscp,
                                           bit sv, logic [11:0] vid, logic [3:0] port);
        logic [37:0] up;
        up = 38'({$urandom(), $urandom()});
        return {up, port, vid, sv, dscp, sd, dec, drop};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < HB; i++) cur_hdr[i] = 8'($urandom());
    endtask

    task automatic set_ipv4(input bit vlan, input logic [7:0] tos, input logic [7:0] ttl,
                            input logic [15:0] csum);
        int b;
        b = vlan ? 18 : 14;
        if (vlan) begin
            cur_hdr[12] = 8'h81; cur_hdr[13] = 8'h00;
            cur_hdr[16] = 8'h08; cur_hdr[17] = 8'h00;
        end else begin
            cur_hdr[12] = 8'h08; cur_hdr[13] = 8'h00;
        end
        cur_hdr[b]    = 8'h45;
        cur_hdr[b+1]  = tos;
        cur_hdr[b+8]  = ttl;
        cur_hdr[b+9]  = 8'h06;
        cur_hdr[b+10] = csum[15:8];
        cur_hdr[b+11] = csum[7:0];
    endtask

    // Reference model: applies the edit rules to a byte array and queues the result
    task automatic model_push(input int len, input bit vlan, input bit ip,
                              input logic [63:0] act, output bit dropped);
        logic [7:0] o [HB];
        int         b;
        bit         ipok;
        b    = vlan ? 18 : 14;
        ipok = ip && (len >= b + 20);
        o    = cur_hdr;
        dropped = act[0] || (len == 0) || (len > HB) || (act[1] && ipok && cur_hdr[b+8] <= 8'd1);
        if (dropped) return;
        if (ipok) begin
            if (act[2]) o[b+1] = {act[8:3], cur_hdr[b+1][1:0]};
            if (act[1]) o[b+8] = cur_hdr[b+8] - 8'd1;
`ifdef ACTION_TX_CSUM_FIX_EN
            if (act[1] || act[2]) begin
                logic [15:0] nhc, na0, b0, na8, b8, r;
                int s;
                nhc = ~{cur_hdr[b+10], cur_hdr[b+11]};
                na0 = ~{cur_hdr[b], cur_hdr[b+1]};
                b0  = {o[b], o[b+1]};
                na8 = ~{cur_hdr[b+8], cur_hdr[b+9]};
                b8  = {o[b+8], o[b+9]};
                s = int'(nhc) + int'(na0) + int'(b0) + int'(na8) + int'(b8);
                while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
                r = s[15:0];
                r = ~r;
                o[b+10] = r[15:8];
                o[b+11] = r[7:0];
            end
`endif
        end
        if (vlan && act[9]) begin
            o[14] = {cur_hdr[14][7:4], act[21:18]};
            o[15] = act[17:10];
        end
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.data = o[k];
            e.last = (k == len - 1);
            e.port = act[25:22];
            exp_q.push_back(e);
        end
    endtask

    // Present one descriptor, wait for acceptance and check the first reaction
    task automatic issue_pkt(input int len, input bit vlan, input bit ip, input logic [63:0] act);
        int n;
        bit dropped;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 1000 cycles");
            return;
        end
        for (int i = 0; i < HB; i++) hdr_flat[8*i +: 8] = cur_hdr[i];
        hdr_len   = 9'(len);
        has_vlan  = vlan;
        is_ipv4   = ip;
        action    = act;
        hdr_valid = 1'b1;
        act_valid = 1'b1;
        @(posedge clk);
        model_push(len, vlan, ip, act, dropped);
        hs_count = 0;
        if (dropped) model_drop++;
        else         pkt_pending = 1;
        #1;
        hdr_valid = 1'b0;
        act_valid = 1'b0;
        @(negedge clk);
        check("tx_valid_after_accept", tx_valid, !dropped);
        check("drop_cnt", drop_cnt, model_drop);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL pkt_done_wait: %0d bytes outstanding after 5000 cycles", exp_q.size());
        end
        if (pkt_pending) begin
            model_pkt++;
            pkt_pending = 0;
        end
        check("tx_pkt_cnt", tx_pkt_cnt, model_pkt);
    endtask

    // Downstream ready pattern: always, random or alternating
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = ~tx_ready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stalls and the idle gap
    initial begin
        bit          stalled;
        bit          idle_next;
        logic [12:0] held;
        stalled = 0;
        idle_next = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                idle_next = 0;
            end else begin
                if (idle_next) begin
                    check("idle_gap", {in_ready, tx_valid}, 2'b10);
                    idle_next = 0;
                end
                if (stalled)
                    check("stall_hold", {tx_valid, tx_data, tx_last, tx_port}, {1'b1, held});
                stalled = 0;
                if (tx_valid) begin
                    if (tx_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_byte: got 0x%0h expected no output", tx_data);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("tx_data", tx_data, e.data);
                            check("tx_last", tx_last, e.last);
                            check("tx_port", tx_port, e.port);
                            hs_count++;
                            if (e.last) idle_next = 1;
                        end
                    end else begin
                        stalled = 1;
                        held = {tx_data, tx_last, tx_port};
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_port", tx_port, 0);
        check("rst_pkt_cnt", tx_pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Untagged IPv4 pass-through to port 3
        fill_random();
        set_ipv4(0, 8'h00, 8'd64, 16'h1234);
        issue_pkt(60, 0, 1, mk_act(0, 0, 0, 6'd0, 0, 12'd0, 4'd3));
        wait_done();

        // TTL decrement with checksum 0xB1E6
        fill_random();
        set_ipv4(0, 8'h00, 8'd64, 16'hB1E6);
        issue_pkt(60, 0, 1, mk_act(0, 1, 0, 6'd0, 0, 12'd0, 4'd5));
        wait_done();

        // Explicit drop, then TTL=1 with dec_ttl
        fill_random();
        set_ipv4(0, 8'h00, 8'd64, 16'h0000);
        issue_pkt(60, 0, 1, mk_act(1, 0, 0, 6'd0, 0, 12'd0, 4'd2));
        wait_done();
        set_ipv4(0, 8'h00, 8'd1, 16'h0000);
        issue_pkt(60, 0, 1, mk_act(0, 1, 0, 6'd0, 0, 12'd0, 4'd2));
        wait_done();

        // Tagged header: VID rewrite and DSCP 46
        fill_random();
        set_ipv4(1, 8'h01, 8'd64, 16'hBEEF);
        cur_hdr[14] = 8'hA0; cur_hdr[15] = 8'h05;
        issue_pkt(64, 1, 1, mk_act(0, 0, 1, 6'd46, 1, 12'h123, 4'd7));
        wait_done();

        // Length boundaries: zero, oversize, full buffer, single byte
        fill_random();
        issue_pkt(0, 0, 0, mk_act(0, 0, 0, 6'd0, 0, 12'd0, 4'd1));
        wait_done();
        issue_pkt(HB + 8, 0, 0, mk_act(0, 0, 0, 6'd0, 0, 12'd0, 4'd1));
        wait_done();
        issue_pkt(HB, 1, 1, mk_act(0, 1, 1, 6'd10, 1, 12'hFFF, 4'd9));
        wait_done();
        issue_pkt(1, 0, 1, mk_act(0, 1, 0, 6'd0, 0, 12'd0, 4'd15));
        wait_done();
        // IPv4 flag but too short for edits: no TTL drop, bytes unchanged
        set_ipv4(0, 8'h00, 8'd0, 16'h0000);
        issue_pkt(33, 0, 1, mk_act(0, 1, 1, 6'd63, 0, 12'd0, 4'd4));
        wait_done();

        // Alternating ready, then reset in the middle of the packet
        ready_mode = 2;
        fill_random();
        set_ipv4(0, 8'h00, 8'd20, 16'h4321);
        issue_pkt(60, 0, 1, mk_act(0, 1, 0, 6'd0, 0, 12'd0, 4'd6));
        n = 0;
        while (hs_count < 10 && n < 500) begin @(negedge clk); n++; end
        check("bytes_before_reset", hs_count >= 10, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        pkt_pending = 0;
        model_pkt = '0;
        model_drop = '0;
        #1;
        check("mid_rst_outputs", {tx_valid, tx_last, tx_data, tx_port}, 14'd0);
        check("mid_rst_pkt_cnt", tx_pkt_cnt, model_pkt);
        check("mid_rst_drop_cnt", drop_cnt, model_drop);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        fill_random();
        set_ipv4(0, 8'h00, 8'd9, 16'h0F0F);
        issue_pkt(40, 0, 1, mk_act(0, 1, 1, 6'd3, 0, 12'd0, 4'd8));
        wait_done();

        // Randomized traffic with random backpressure
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int  len, sel;
            bit  vlan, ip;
            logic [7:0] ttl;
            fill_random();
            vlan = 1'($urandom_range(0, 1));
            ip   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            ttl  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd2 : 8'($urandom());
            if (ip) set_ipv4(vlan, 8'($urandom()), ttl, 16'($urandom()));
            sel = $urandom_range(0, 9);
            len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(HB + 1, 250) : $urandom_range(1, HB);
            issue_pkt(len, vlan, ip,
                      mk_act($urandom_range(0, 7) == 0, 1'($urandom()), 1'($urandom()),
                             6'($urandom()), 1'($urandom()), 12'($urandom()), 4'($urandom())));
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
